aes_key_sequencer: RTL

//  Synthesizable host-side initiator for the AES pipeline. Accepts a 256-bit key and sends it to both
//  key_user_intel expansion units (LSB, flag 8'h01; MSB, flag 8'h02), then captures the two 1024-bit halves.

---
 rtl/aes_pkg.sv | 9 +
 rtl/aes_pipe_reg.sv | 24 ++
 rtl/aes_key_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared types, expander flags and config-word builder for the AES key sequencer.
package aes_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STREAM} state_t;
    localparam logic [7:0] FLAG_LSB = 8'h01;
    localparam logic [7:0] FLAG_MSB = 8'h02;
    function automatic logic [255:0] config_word(input logic [31:0] elements);
        return {128'h0, 32'h0, elements, 64'h0};
    endfunction
endpackage

// File: rtl/aes_pipe_reg.sv
// aes_pipe_reg: single-entry valid/ready register slice that carries one data beat at full rate.
module aes_pipe_reg #(
    parameter int W = 512
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    assign in_ready = !out_valid || out_ready;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end
endmodule

// File: rtl/aes_key_sequencer.sv
// aes_key_sequencer: issues a raw key to both expanders, captures the expanded halves,
// then streams a fixed number of data beats into the AES core with key and config attached.
module aes_key_sequencer
    import aes_pkg::*;
#(
    parameter int N_PIPES   = 4,
    parameter int KEY_WIDTH = 256,
    parameter int HALF_W    = 1024,
    parameter int CNT_W     = 32
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   key_valid,
    output logic                   key_ready,
    input  logic [KEY_WIDTH-1:0]   key_in,
    input  logic [CNT_W-1:0]       elements,
    output logic                   kl_ivalid,
    output logic                   km_ivalid,
    input  logic                   kl_oready,
    input  logic                   km_oready,
    output logic [KEY_WIDTH-1:0]   kx_datain,
    input  logic                   kl_ovalid,
    input  logic                   km_ovalid,
    output logic                   kl_iready,
    output logic                   km_iready,
    input  logic [HALF_W-1:0]      kl_dataout,
    input  logic [HALF_W-1:0]      km_dataout,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [N_PIPES*128-1:0] s_data,
    output logic                   aes_ivalid,
    input  logic                   aes_oready,
    output logic [N_PIPES*128-1:0] aes_datain,
    output logic [255:0]           aes_configin,
    output logic [HALF_W-1:0]      aes_keylsbin,
    output logic [HALF_W-1:0]      aes_keymsbin,
    output logic                   keys_loaded,
    output logic                   busy
);
    state_t state, state_nx;
    logic kl_got, km_got, kl_cap, km_cap, key_fire, both_sent, both_cap, last_out;
    logic gate, pipe_ready, s_fire;
    logic [CNT_W-1:0] elements_q, remaining;

    assign key_ready    = state == IDLE;
    assign busy         = state != IDLE;
    assign kl_iready    = state == WAIT && !kl_got;
    assign km_iready    = state == WAIT && !km_got;
    assign key_fire     = key_valid && key_ready;
    assign kl_cap       = kl_ovalid && kl_iready;
    assign km_cap       = km_ovalid && km_iready;
    assign both_sent    = (!kl_ivalid || kl_oready) && (!km_ivalid || km_oready);
    assign both_cap     = (kl_got || kl_cap) && (km_got || km_cap);
    assign last_out     = aes_ivalid && aes_oready && remaining == '0;
    assign gate         = state == STREAM && remaining != '0;
    assign s_ready      = gate && pipe_ready;
    assign s_fire       = s_valid && s_ready;
    assign aes_configin = config_word(32'(elements_q));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   state_nx = key_fire ? ISSUE : IDLE;
            ISSUE:  state_nx = both_sent ? WAIT : ISSUE;
            WAIT:   state_nx = !both_cap ? WAIT : (elements_q == '0 ? IDLE : STREAM);
            STREAM: state_nx = last_out ? IDLE : STREAM;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Key issue and half capture; everything persists after IDLE until the next key.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            kx_datain    <= '0;
            elements_q   <= '0;
            kl_ivalid    <= 1'b0;
            km_ivalid    <= 1'b0;
            kl_got       <= 1'b0;
            km_got       <= 1'b0;
            aes_keylsbin <= '0;
            aes_keymsbin <= '0;
            keys_loaded  <= 1'b0;
        end else if (key_fire) begin
            kx_datain   <= key_in;
            elements_q  <= elements;
            kl_ivalid   <= 1'b1;
            km_ivalid   <= 1'b1;
            kl_got      <= 1'b0;
            km_got      <= 1'b0;
            keys_loaded <= 1'b0;
        end else begin
            if (kl_ivalid && kl_oready) kl_ivalid <= 1'b0;
            if (km_ivalid && km_oready) km_ivalid <= 1'b0;
            if (kl_cap) begin
                aes_keylsbin <= kl_dataout;
                kl_got       <= 1'b1;
            end
            if (km_cap) begin
                aes_keymsbin <= km_dataout;
                km_got       <= 1'b1;
            end
            if (state == WAIT && both_cap) keys_loaded <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                       remaining <= '0;
        else if (state == WAIT && both_cap) remaining <= elements_q;
        else if (s_fire)                   remaining <= remaining - 1'b1;
    end

    aes_pipe_reg #(.W(N_PIPES*128)) u_pipe (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (s_valid && gate),
        .in_ready  (pipe_ready),
        .in_data   (s_data),
        .out_valid (aes_ivalid),
        .out_ready (aes_oready),
        .out_data  (aes_datain)
    );
endmodule
